fetch_unit: RTL and testbench

Instruction fetch unit that sits directly upstream of the processor's instruction dispatch. It owns the fetch address and issues reads to memory with a configurable number of wait states. Fetched bytes go into a small prefetch FIFO, and the head byte is presented to pipeline stage 1. Jumps from stage 2 flush the FIFO and redirect fetch; a halt request freezes issue without discarding fetched bytes.

---
 rtl/fetch_unit_if.sv | 9 +
 rtl/fetch_unit.sv | 134 +++++++++++++
 tb/tb_fetch_unit.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Memory read bus between the fetch unit (master) and instruction memory (slave).
interface fetch_unit_if;
  logic [15:0] MEM_ADDR;
  logic        MEM_OE_bar;
  logic [7:0]  MEM_DATA;

  modport master (output MEM_ADDR, output MEM_OE_bar, input MEM_DATA);
  modport slave  (input MEM_ADDR, input MEM_OE_bar, output MEM_DATA);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: wait-stated memory reads into a tagged prefetch FIFO.
// Optional FETCH_PERF_EN adds a saturating STALL_COUNT output.
module fetch_unit #(
  parameter int          DEPTH        = 4,
  parameter int          WAIT_STATES  = 1,
  parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
  input  logic         CLK,
  input  logic         RST_bar,
  fetch_unit_if.master mem,
  input  logic         JUMP,
  input  logic [15:0]  JUMP_ADDR,
  input  logic         HALT,
  output logic [7:0]   INSTR,
  output logic         INSTR_VALID,
  input  logic         INSTR_TAKE,
  output logic [15:0]  PC,
  output logic [4:0]   LEVEL
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]  STALL_COUNT
`endif
);
  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0]  DEPTH_L = 5'(DEPTH);
  localparam logic [2:0]  WS_L    = 3'(WAIT_STATES);

  typedef enum logic {IDLE, READ} state_t;

  state_t          r_state, w_state_nx;
  logic [2:0]      r_cnt, w_cnt_nx;
  logic [15:0]     r_faddr, r_maddr;
  logic            r_oe_n;
  logic [4:0]      r_level;
  logic [AW-1:0]   r_rd, r_wr;
  logic [7:0]      r_data [DEPTH];
  logic [15:0]     r_tag  [DEPTH];

  logic            w_take, w_done, w_push, w_issue;
  logic [4:0]      w_level_nx;
  logic [15:0]     w_issue_addr;

  assign w_take       = INSTR_TAKE && (r_level != 5'd0) && !JUMP;
  assign w_done       = (r_state == READ) && (r_cnt == 3'd0);
  assign w_push       = w_done && !JUMP;
  assign w_level_nx   = r_level + 5'(w_push) - 5'(w_take);
  // A back-to-back read targets the address after the one completing now.
  assign w_issue_addr = w_done ? r_faddr + 16'd1 : r_faddr;

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_issue    = 1'b0;
    if (JUMP) begin
      w_state_nx = IDLE;
      w_cnt_nx   = 3'd0;
    end else begin
      case (r_state)
        IDLE: if (!HALT && w_level_nx < DEPTH_L) begin
          w_issue    = 1'b1;
          w_state_nx = READ;
          w_cnt_nx   = WS_L;
        end
        READ: begin
          if (r_cnt != 3'd0) begin
            w_cnt_nx = r_cnt - 3'd1;
          end else if (!HALT && w_level_nx < DEPTH_L) begin
            w_issue  = 1'b1;
            w_cnt_nx = WS_L;
          end else begin
            w_state_nx = IDLE;
          end
        end
        default: w_state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_bar) begin
    if (!RST_bar) begin
      r_state <= IDLE;
      r_cnt   <= 3'd0;
      r_faddr <= RESET_VECTOR;
      r_maddr <= RESET_VECTOR;
      r_oe_n  <= 1'b1;
      r_level <= 5'd0;
      r_rd    <= '0;
      r_wr    <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_oe_n  <= (w_state_nx != READ);
      if (w_issue) r_maddr <= w_issue_addr;
      if (JUMP) begin
        r_faddr <= JUMP_ADDR;
        r_level <= 5'd0;
        r_rd    <= '0;
        r_wr    <= '0;
      end else begin
        if (w_push) begin
          r_faddr <= r_faddr + 16'd1;
          r_wr    <= r_wr + AW'(1);
        end
        if (w_take) r_rd <= r_rd + AW'(1);
        r_level <= w_level_nx;
      end
    end
  end

  // Storage needs no reset: entries are only visible below r_level.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_data[r_wr] <= mem.MEM_DATA;
      r_tag[r_wr]  <= r_faddr;
    end
  end

  assign mem.MEM_ADDR   = r_maddr;
  assign mem.MEM_OE_bar = r_oe_n;
  assign INSTR_VALID    = (r_level != 5'd0);
  assign INSTR          = INSTR_VALID ? r_data[r_rd] : 8'h00;
  assign PC             = INSTR_VALID ? r_tag[r_rd] : r_faddr;
  assign LEVEL          = r_level;

`ifdef FETCH_PERF_EN
  logic [15:0] r_stall;
  always_ff @(posedge CLK or negedge RST_bar) begin
    if (!RST_bar)                                            r_stall <= 16'd0;
    else if (JUMP)                                           r_stall <= 16'd0;
    else if (!INSTR_VALID && !HALT && r_stall != 16'hFFFF)   r_stall <= r_stall + 16'd1;
  end
  assign STALL_COUNT = r_stall;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized + directed bench for fetch_unit against a queue-based reference model.
module tb_fetch_unit;
  localparam int DEPTH = 4;
  localparam int WS    = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        jump = 1'b0, halt = 1'b0, take = 1'b0;
  logic [15:0] jaddr = 16'h0;
  logic [7:0]  instr;
  logic        ivalid;
  logic [15:0] pc;
  logic [4:0]  level;
`ifdef FETCH_PERF_EN
  logic [15:0] stall;
`endif

  fetch_unit_if bus ();
  assign bus.MEM_DATA = bus.MEM_ADDR[7:0] + 8'd1;

  fetch_unit #(.DEPTH(DEPTH), .WAIT_STATES(WS), .RESET_VECTOR(16'h0000)) dut (
    .CLK(clk), .RST_bar(rst_n), .mem(bus),
    .JUMP(jump), .JUMP_ADDR(jaddr), .HALT(halt),
    .INSTR(instr), .INSTR_VALID(ivalid), .INSTR_TAKE(take),
    .PC(pc), .LEVEL(level)
`ifdef FETCH_PERF_EN
    , .STALL_COUNT(stall)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: queue of fetched (addr,data), one outstanding read.
  typedef struct { logic [15:0] a; logic [7:0] d; } ent_t;
  ent_t        q[$];
  bit          m_busy;
  int          m_left;
  logic [15:0] m_faddr, m_maddr, m_stall;

  function automatic logic [7:0] memf(input logic [15:0] a);
    return a[7:0] + 8'd1;
  endfunction

  task automatic model_reset();
    q.delete();
    m_busy = 0; m_left = 0;
    m_faddr = 16'h0000; m_maddr = 16'h0000; m_stall = 16'h0;
  endtask

  task automatic model_step(input bit j, input logic [15:0] ja, input bit h, input bit t);
    bit   was_valid, done;
    ent_t e;
    was_valid = q.size() > 0;
    if (j) begin
      q.delete(); m_busy = 0; m_faddr = ja; m_stall = 16'h0;
    end else begin
      if (!was_valid && !h && m_stall != 16'hFFFF) m_stall++;
      done = 0;
      if (m_busy) begin
        if (m_left == 0) begin
          e.a = m_faddr; e.d = memf(m_faddr);
          q.push_back(e);
          m_faddr++;
          done = 1;
        end else m_left--;
      end
      if (t && was_valid) void'(q.pop_front());
      if ((!m_busy || done) && !h && q.size() < DEPTH) begin
        m_busy = 1; m_left = WS; m_maddr = m_faddr;
      end else if (done) m_busy = 0;
    end
  endtask

  task automatic check_outputs();
    bit v;
    v = q.size() > 0;
    chk("level", level, q.size());
    chk("valid", ivalid, v);
    chk("instr", instr, v ? q[0].d : 8'h00);
    chk("pc",    pc,    v ? q[0].a : m_faddr);
    chk("oe",    bus.MEM_OE_bar, !m_busy);
    if (m_busy) chk("maddr", bus.MEM_ADDR, m_maddr);
`ifdef FETCH_PERF_EN
    chk("stall", stall, m_stall);
`endif
  endtask

  task automatic cyc(input bit j, input logic [15:0] ja, input bit h, input bit t);
    jump = j; jaddr = ja; halt = h; take = t;
    @(posedge clk);
    model_step(j, ja, h, t);
    #1 check_outputs();
  endtask

  initial begin
    logic [15:0] wexp [3];
    int n, k;
    bit hit;
    wexp[0] = 16'hFFFE; wexp[1] = 16'hFFFF; wexp[2] = 16'h0000;
    model_reset();

    // Reset state
    #12;
    check_outputs();
    chk("rst_maddr", bus.MEM_ADDR, 16'h0000);
    @(negedge clk) rst_n = 1'b1;

    // Reset sequencing, no takes
    for (int e = 1; e <= 10; e++) begin
      cyc(0, 16'h0, 0, 0);
      if (e == 1) begin
        chk("rs_addr0", bus.MEM_ADDR, 16'h0000);
        chk("rs_oe0", bus.MEM_OE_bar, 1'b0);
      end
      if (e == 3) begin
        chk("rs_instr", instr, 8'h01);
        chk("rs_pc", pc, 16'h0000);
      end
      if (e == 9) begin
        chk("rs_level4", level, 5'd4);
        chk("rs_oe_stop", bus.MEM_OE_bar, 1'b1);
      end
    end

    // Wrap across 16'hFFFF
    cyc(1, 16'hFFFE, 0, 0);
    n = 0;
    for (int i = 0; i < 20 && n < 3; i++) begin
      if (ivalid) begin
        chk("wrap_pc", pc, wexp[n]);
        n++;
        cyc(0, 16'h0, 0, 1);
      end else cyc(0, 16'h0, 0, 0);
    end
    chk("wrap_done", n, 3);

    // Jump while a read is in flight
    cyc(1, 16'h0040, 0, 0);
    cyc(0, 16'h0, 0, 0);
    chk("jm_inflight", bus.MEM_OE_bar, 1'b0);
    cyc(1, 16'h0100, 0, 0);
    chk("jm_level0", level, 5'd0);
    k = 0; hit = 0;
    for (int i = 1; i <= 10 && !hit; i++) begin
      cyc(0, 16'h0, 0, 0);
      if (ivalid) begin hit = 1; k = i; end
    end
    chk("jm_latency", k, WS + 2);
    chk("jm_instr", instr, 8'h01);
    chk("jm_pc", pc, 16'h0100);

    // Halt with LEVEL=2 and a read in flight
    cyc(1, 16'h0200, 0, 0);
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      cyc(0, 16'h0, 0, 0);
      if (level == 5'd2 && bus.MEM_OE_bar == 1'b0) hit = 1;
    end
    chk("ht_reach2", hit, 1'b1);
    for (int i = 0; i < 4; i++) cyc(0, 16'h0, 1, 0);
    chk("ht_level3", level, 5'd3);
    chk("ht_oe_off", bus.MEM_OE_bar, 1'b1);
    for (int i = 0; i < 3; i++) cyc(0, 16'h0, 1, 1);
    chk("ht_empty", ivalid, 1'b0);
    chk("ht_instr0", instr, 8'h00);
    cyc(0, 16'h0, 0, 0);
    chk("ht_resume_oe", bus.MEM_OE_bar, 1'b0);
    chk("ht_resume_addr", bus.MEM_ADDR, 16'h0203);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] ja;
      ja = ($urandom_range(0, 3) == 0) ? 16'hFFF0 + 16'($urandom_range(0, 15))
                                       : 16'($urandom());
      cyc($urandom_range(0, 99) < 3, ja, $urandom_range(0, 99) < 15,
          $urandom_range(0, 99) < 55);
      if (q.size() > DEPTH) chk("model_overflow", q.size(), DEPTH);
    end

    // Async reset mid-read with FIFO nearly full
    hit = 0;
    for (int i = 0; i < 30 && !hit; i++) begin
      cyc(0, 16'h0, 0, 0);
      if (level >= 5'd3 && bus.MEM_OE_bar == 1'b0) hit = 1;
    end
    chk("ar_setup", hit, 1'b1);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    chk("ar_maddr", bus.MEM_ADDR, 16'h0000);
    chk("ar_instr", instr, 8'h00);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 6; i++) cyc(0, 16'h0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
